uart_rx_frontend: RTL and testbench

- UART 8N1 receiver stage directly upstream of the keychain core; sits on rx_wire_in and produces bytes for keychain's input parser.
- Synchronises the asynchronous RX line and detects the start bit with a glitch check.
- Samples each bit at mid-period and presents bytes over a valid/ready handshake with framing-error and overrun reporting.

---
 rtl/uart_rx_frontend.sv | 124 ++++++++++++
 tb/tb_uart_rx_frontend.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receiver: 2-flop synchroniser, start-bit glitch check, mid-bit sampling.
// Byte valid 1 cycle after the stop sample; held until accepted, later bytes dropped with overrun pulse.
module uart_rx_frontend #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rx_wire_in,
   output logic [7:0] data_byte_out,
   output logic       data_valid_out,
   input  logic       data_ready_in,
   output logic       framing_error_out,
   output logic       overrun_out,
   output logic       busy_out
);

   localparam int BIT_PERIOD  = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF_PERIOD = BIT_PERIOD / 2;
   localparam int CW          = $clog2(BIT_PERIOD) + 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_PERIOD - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t          state;
   logic            rx_m;
   logic            rx_s;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rx_m              <= 1'b1;
         rx_s              <= 1'b1;
         state             <= IDLE;
         cnt               <= '0;
         bit_idx           <= '0;
         shift             <= '0;
         data_byte_out     <= '0;
         data_valid_out    <= 1'b0;
         framing_error_out <= 1'b0;
         overrun_out       <= 1'b0;
         busy_out          <= 1'b0;
      end else begin
         rx_m              <= rx_wire_in;
         rx_s              <= rx_m;
         framing_error_out <= 1'b0;
         overrun_out       <= 1'b0;
         if (data_valid_out && data_ready_in)
            data_valid_out <= 1'b0;

         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (!rx_s) begin
                  state    <= START;
                  busy_out <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  // a start bit that is already high again at mid-bit is a glitch
                  if (rx_s) begin
                     state    <= IDLE;
                     busy_out <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shift <= {rx_s, shift[7:1]};
                  if (bit_idx == 3'd7)
                     state <= STOP;
                  else
                     bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state    <= IDLE;
                     busy_out <= 1'b0;
                     // a byte accepted this very cycle frees the slot for the new one
                     if (!data_valid_out || data_ready_in) begin
                        data_byte_out  <= shift;
                        data_valid_out <= 1'b1;
                     end else begin
                        overrun_out <= 1'b1;
                     end
                  end else begin
                     framing_error_out <= 1'b1;
                     state             <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_HIGH: begin
               if (rx_s) begin
                  state    <= IDLE;
                  busy_out <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               busy_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: directed scenarios plus random frames, checked each cycle
// against a frame-level scoreboard of expected deliveries, errors and busy points.
module tb_uart_rx_frontend;

   localparam int CF   = 1_700_000;
   localparam int BR   = 100_000;
   localparam int BIT  = CF / BR;       // 17
   localparam int HALF = BIT / 2;       // 8

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       rx_wire_in = 1'b1;
   logic       data_ready_in = 1'b1;
   logic [7:0] data_byte_out;
   logic       data_valid_out;
   logic       framing_error_out;
   logic       overrun_out;
   logic       busy_out;

   uart_rx_frontend #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .rx_wire_in        (rx_wire_in),
      .data_byte_out     (data_byte_out),
      .data_valid_out    (data_valid_out),
      .data_ready_in     (data_ready_in),
      .framing_error_out (framing_error_out),
      .overrun_out       (overrun_out),
      .busy_out          (busy_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {int c; bit fe; logic [7:0] b;} ev_t;
   typedef struct {int c; bit v;} bchk_t;

   ev_t   evq[$];
   bchk_t bq[$];

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   bit         rand_ready = 1'b0;
   bit         chk0 = 1'b0;
   bit         m_valid = 1'b0;
   logic [7:0] m_byte = 8'h00;
   bit         m_fe = 1'b0;
   bit         m_ovr = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: check outputs for the current cycle, advance the model across the edge.
   task automatic cycle();
      bit accept;
      @(negedge clk_in);
      chk("valid", data_valid_out, m_valid);
      chk("ferr", framing_error_out, m_fe);
      chk("ovr", overrun_out, m_ovr);
      if (m_valid) chk("byte", data_byte_out, m_byte);
      if (chk0) begin
         chk("rst_byte", data_byte_out, 0);
         chk0 = 1'b0;
      end
      while (bq.size() > 0 && bq[0].c == cyc) begin
         chk("busy", busy_out, bq[0].v);
         void'(bq.pop_front());
      end
      m_fe  = 1'b0;
      m_ovr = 1'b0;
      if (rst_in) begin
         m_valid = 1'b0;
         m_byte  = 8'h00;
         while (evq.size() > 0 && evq[evq.size()-1].c > cyc) void'(evq.pop_back());
         while (bq.size() > 0 && bq[bq.size()-1].c > cyc) void'(bq.pop_back());
         bq.push_back('{cyc + 1, 1'b0});
         chk0 = 1'b1;
      end else begin
         accept = m_valid && data_ready_in;
         if (accept) m_valid = 1'b0;
         if (evq.size() > 0 && evq[0].c == cyc + 1) begin
            if (evq[0].fe) begin
               m_fe = 1'b1;
            end else if (!m_valid) begin
               m_valid = 1'b1;
               m_byte  = evq[0].b;
            end else begin
               m_ovr = 1'b1;
            end
            void'(evq.pop_front());
         end
      end
      @(posedge clk_in);
      #1;
      cyc++;
      if (rand_ready) data_ready_in = 1'($urandom_range(0, 1));
   endtask

   // t0 is two cycles after the start bit is driven; result appears one cycle after the stop sample.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_after, input int idle_after);
      int t0, s;
      t0 = cyc + 2;
      s  = t0 + HALF + 9 * BIT;
      evq.push_back('{s + 1, !stop_ok, b});
      bq.push_back('{t0 + 1, 1'b1});
      bq.push_back('{s, 1'b1});
      bq.push_back('{s + 1, !stop_ok});
      rx_wire_in = 1'b0;
      repeat (BIT) cycle();
      for (int i = 0; i < 8; i++) begin
         rx_wire_in = b[i];
         repeat (BIT) cycle();
      end
      rx_wire_in = stop_ok;
      repeat (BIT) cycle();
      rx_wire_in = 1'b0;
      repeat (low_after) cycle();
      rx_wire_in = 1'b1;
      repeat (idle_after) cycle();
   endtask

   task automatic send_glitch(input int low_len);
      int t0;
      t0 = cyc + 2;
      bq.push_back('{t0 + 1, 1'b1});
      bq.push_back('{t0 + HALF, 1'b1});
      bq.push_back('{t0 + HALF + 1, 1'b0});
      rx_wire_in = 1'b0;
      repeat (low_len) cycle();
      rx_wire_in = 1'b1;
      repeat (2 * BIT) cycle();
   endtask

   task automatic send_aborted(input logic [7:0] b, input int abort_bit);
      bq.push_back('{cyc + 3, 1'b1});
      rx_wire_in = 1'b0;
      repeat (BIT) cycle();
      for (int i = 0; i < abort_bit; i++) begin
         rx_wire_in = b[i];
         repeat (BIT) cycle();
      end
      rx_wire_in = b[abort_bit];
      repeat (3) cycle();
      rst_in = 1'b1;
      cycle();
      rst_in = 1'b0;
      rx_wire_in = 1'b1;
      repeat (2 * BIT) cycle();
   endtask

   initial begin
      @(posedge clk_in);
      #1;
      repeat (2) cycle();
      rst_in = 1'b0;
      repeat (BIT) cycle();

      // 1: basic frame, ready high
      data_ready_in = 1'b1;
      send_frame(8'hA5, 1'b1, 0, BIT);
      // 2: short low pulse, longest one that is still rejected
      send_glitch(HALF);
      send_glitch(3);
      // 3: bad stop then break, then recovery
      send_frame(8'h3C, 1'b0, 10 * BIT, BIT);
      send_frame(8'h5A, 1'b1, 0, BIT);
      // 4: overrun while consumer stalls
      data_ready_in = 1'b0;
      send_frame(8'h11, 1'b1, 0, 2);
      send_frame(8'h22, 1'b1, 0, 5);
      data_ready_in = 1'b1;
      repeat (4) cycle();
      // 5: back-to-back frames
      send_frame(8'h00, 1'b1, 0, 0);
      send_frame(8'hFF, 1'b1, 0, BIT);
      // 6: reset mid-frame, then a clean frame
      send_aborted(8'h96, 4);
      send_frame(8'hC3, 1'b1, 0, BIT);

      // random frames, gaps, stop errors and consumer stalls
      rand_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [7:0] b;
         bit ok;
         b  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 5) != 0);
         if (ok)
            send_frame(b, 1'b1, 0, $urandom_range(0, BIT));
         else
            send_frame(b, 1'b0, $urandom_range(0, BIT), $urandom_range(2, BIT));
         if ($urandom_range(0, 7) == 0) send_glitch($urandom_range(1, HALF));
      end
      rand_ready = 1'b0;
      data_ready_in = 1'b1;
      repeat (3 * BIT) cycle();

      chk("events_left", evq.size(), 0);
      chk("busy_left", bq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
